// File: rtl/truth_table_step_checker_pkg.sv
// Shared definitions for the truth-table step checker: parameter defaults,
// sequencer state encoding and a popcount helper for the fail vector.
package truth_table_step_checker_pkg;

  localparam int DEF_CH_NUM   = 8;
  localparam int DEF_STEP_W   = 8;
  localparam int DEF_SETTLE_W = 16;
  localparam int DEF_ERR_W    = 16;

  // The popcount helper is sized for up to POP_MAX_W channels.
  localparam int POP_MAX_W = 64;
  localparam int POP_CNT_W = 7;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [POP_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + POP_CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/truth_table_settle_timer.sv
// Settle-delay timer: after a load with count N, o_expire pulses in the N-th
// following cycle, or in the load cycle itself when N is zero.
module truth_table_settle_timer
  import truth_table_step_checker_pkg::*;
#(
  parameter int SETTLE_W = DEF_SETTLE_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [SETTLE_W-1:0] i_count,
  output logic                o_expire
);

  logic [SETTLE_W-1:0] remain;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      remain <= '0;
    end else if (i_load) begin
      remain <= i_count;
    end else if (remain != '0) begin
      remain <= remain - SETTLE_W'(1);
    end
  end

  assign o_expire = i_load ? (i_count == '0) : (remain == SETTLE_W'(1));

endmodule

// File: rtl/truth_table_step_checker.sv
// Truth-table run sequencer: requests each vector, waits the settle time,
// strobes the detectors for one cycle and accumulates the fail results.
module truth_table_step_checker
  import truth_table_step_checker_pkg::*;
#(
  parameter int CH_NUM   = DEF_CH_NUM,
  parameter int STEP_W   = DEF_STEP_W,
  parameter int SETTLE_W = DEF_SETTLE_W,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [STEP_W-1:0]   i_step_total,
  input  logic [SETTLE_W-1:0] i_settle_cycles,
  input  logic [CH_NUM-1:0]   i_channel_mask,
  output logic                o_step_req,
  output logic [STEP_W-1:0]   o_step_idx,
  input  logic                i_step_ack,
  output logic [CH_NUM-1:0]   o_channel_vld,
  input  logic [CH_NUM-1:0]   i_detect_vld,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [CH_NUM-1:0]   o_fail_ch_map,
  output logic [ERR_W-1:0]    o_err_cnt,
  output logic                o_first_fail_vld,
  output logic [STEP_W-1:0]   o_first_fail_step
);

  localparam int SUM_W = ERR_W + POP_CNT_W;

  logic [2:0]           state;
  logic [STEP_W-1:0]    total_q;
  logic [SETTLE_W-1:0]  settle_q;
  logic [CH_NUM-1:0]    mask_q;
  logic                 timer_load;
  logic                 timer_expire;
  logic [CH_NUM-1:0]    fail;
  logic [POP_CNT_W-1:0] fail_cnt;
  logic [SUM_W-1:0]     err_sum;
  logic [ERR_W-1:0]     err_next;

  truth_table_settle_timer #(
    .SETTLE_W (SETTLE_W)
  ) u_settle_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (timer_load),
    .i_count  (settle_q),
    .o_expire (timer_expire)
  );

  assign timer_load = (state == ST_REQ) && i_step_ack && (settle_q != '0);

  // Detector outputs are combinational, so the fail vector is valid in SAMPLE.
  assign fail     = mask_q & ~i_detect_vld;
  assign fail_cnt = popcount(POP_MAX_W'(fail));
  assign err_sum  = SUM_W'(o_err_cnt) + SUM_W'(fail_cnt);
  assign err_next = (err_sum > SUM_W'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];

  assign o_step_req    = (state == ST_REQ);
  assign o_channel_vld = (state == ST_SAMPLE) ? mask_q : '0;
  assign o_done        = (state == ST_DONE);
  assign o_busy        = (state != ST_IDLE) && (state != ST_DONE);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state             <= ST_IDLE;
      total_q           <= '0;
      settle_q          <= '0;
      mask_q            <= '0;
      o_step_idx        <= '0;
      o_pass            <= 1'b1;
      o_fail_ch_map     <= '0;
      o_err_cnt         <= '0;
      o_first_fail_vld  <= 1'b0;
      o_first_fail_step <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            total_q           <= i_step_total;
            settle_q          <= i_settle_cycles;
            mask_q            <= i_channel_mask;
            o_step_idx        <= '0;
            o_pass            <= 1'b1;
            o_fail_ch_map     <= '0;
            o_err_cnt         <= '0;
            o_first_fail_vld  <= 1'b0;
            o_first_fail_step <= '0;
            state             <= (i_step_total == '0) ? ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_step_ack) begin
            state <= (settle_q == '0) ? ST_SAMPLE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (timer_expire) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (fail != '0) begin
            o_fail_ch_map <= o_fail_ch_map | fail;
            o_err_cnt     <= err_next;
            o_pass        <= 1'b0;
            if (!o_first_fail_vld) begin
              o_first_fail_vld  <= 1'b1;
              o_first_fail_step <= o_step_idx;
            end
          end
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          // Compare against total-1 so a full-range total never wraps the index.
          if (o_step_idx == total_q - STEP_W'(1)) begin
            state <= ST_DONE;
          end else begin
            o_step_idx <= o_step_idx + STEP_W'(1);
            state      <= ST_REQ;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/truth_table_step_checker.md
Name: truth_table_step_checker

Overview:
- Sequencer and result collector directly downstream of the per-channel truth-table detectors; also drives their sample strobe.
- Steps through a truth-table run one vector at a time:
  - requests each vector from the stimulus driver;
  - waits a settle time;
  - strobes channel-valid to CH_NUM detectors for one cycle;
  - collects the active-low fail indications.
- Reports per-run pass/fail, a sticky failing-channel map, a saturating error count and the first failing step.

Parameters:
- CH_NUM, 8: number of detector channels.
- STEP_W, 8: width of step index and step total.
- SETTLE_W, 16: width of settle-cycle count.
- ERR_W, 16: width of error counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-low.
- i_start  in  1  start-run pulse; sampled only in IDLE.
- i_step_total  in  STEP_W  number of vectors in the run; latched at start.
- i_settle_cycles  in  SETTLE_W  wait cycles after ack before sampling; latched at start.
- i_channel_mask  in  CH_NUM  channels under test; latched at start.
- o_step_req  out  1  request for the stimulus driver to apply vector o_step_idx.
- o_step_idx  out  STEP_W  current vector index, 0-based.
- i_step_ack  in  1  vector applied; honoured only while o_step_req=1.
- o_channel_vld  out  CH_NUM  sample strobe to the detectors.
- i_detect_vld  in  CH_NUM  detector outputs; 0 = fail while strobed.
- o_busy  out  1  run in progress.
- o_done  out  1  one-cycle run-complete pulse.
- o_pass  out  1  1 if the last run had zero failures.
- o_fail_ch_map  out  CH_NUM  sticky OR of failing channels.
- o_err_cnt  out  ERR_W  saturating count of failing (step, channel) pairs.
- o_first_fail_vld  out  1  at least one failure recorded.
- o_first_fail_step  out  STEP_W  index of the first failing step.

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - state to IDLE;
  - every output 0, except o_pass=1;
  - latched config cleared.
  - Reset mid-run aborts immediately, with no o_done.
- States: IDLE, REQ, SETTLE, SAMPLE, NEXT, DONE.
- IDLE, on i_start=1:
  - latch config; clear o_fail_ch_map, o_err_cnt, o_first_fail_*; set o_pass=1; o_step_idx=0; o_busy=1.
  - If total=0, go to DONE; otherwise go to REQ.
- i_start is ignored in all other states.
- REQ:
  - o_step_req=1 is a level, held until a cycle with i_step_ack=1.
  - An ack in the same cycle req first rises is accepted.
  - On ack: if settle=0 go to SAMPLE; otherwise load the counter and go to SETTLE.
- SETTLE: count down exactly i_settle_cycles cycles, then go to SAMPLE.
- SAMPLE (exactly one cycle):
  - o_channel_vld = latched mask.
  - fail = mask & ~i_detect_vld, evaluated the same cycle (the detector path is combinational).
  - If fail != 0:
    - OR fail into o_fail_ch_map;
    - add popcount(fail) to o_err_cnt, saturating at 2^ERR_W-1 with no wrap;
    - clear o_pass.
  - If fail != 0 and o_first_fail_vld=0: set o_first_fail_vld=1 and o_first_fail_step=o_step_idx.
  - o_channel_vld=0 in every other state.
- NEXT: if o_step_idx = total-1 go to DONE; otherwise increment o_step_idx and go to REQ.
- DONE: o_done=1 for one cycle, o_busy=0, go to IDLE. Results hold until the next start.
- Latency per step: 1 (REQ, with immediate ack) + settle + 1 (SAMPLE) + 1 (NEXT) cycles.
- Boundary conditions:
  - mask=0: no strobes, pass=1.
  - total = 2^STEP_W-1: the index never wraps.
  - Channels with mask=0 can never fail.
- i_detect_vld is don't-care outside SAMPLE.

Decomposition:
- Shared package holds:
  - state encoding localparams;
  - CH_NUM/STEP_W/SETTLE_W/ERR_W defaults;
  - a popcount function of CH_NUM width.
- One natural sub-module: truth_table_settle_timer. It takes a load with count and asserts expire after N cycles, or immediately when N=0.
- The detectors remain separate instances, CH_NUM of them, instantiated by the parent.

Test Plan:
- total=3, settle=2, mask=8'hFF, ack tied 1, all detect=1:
  - o_done after 3×5=15 cycles plus start/done overhead;
  - pass=1, err_cnt=0, map=0, first_fail_vld=0.
- total=4, mask=8'h0F, detect bit2=0 in step 1 and bits 0,3=0 in step 3:
  - map=8'h0D, err_cnt=3, first_fail_step=1, pass=0.
- Failures on masked-off channels (mask=8'hF0, detect bits 3:0 = 0 on every step):
  - pass=1, err_cnt=0, and o_channel_vld never asserts bits 3:0.
- Ack delayed 5 cycles on step 0, and i_start pulsed mid-run:
  - o_step_req held high for 5 cycles;
  - the restart is ignored;
  - o_step_idx does not advance before ack.
- Edge cases:
  - total=0 → o_done within 2 cycles, pass=1, no req or strobe.
  - settle=0 → SAMPLE in the cycle after ack.
- ERR_W=2 with 8 failing channels on step 0 → err_cnt=3 (saturated).
- Reset asserted during SETTLE of step 2 → all outputs reset next cycle, no o_done, fresh start works.
